// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I decode/issue stage.
//   - OP_*      : ALU op_sel encoding consumed by execute
//   - OPC_*     : major opcodes decoded by this stage
//   - F3_*/F7_* : funct3 / funct7 field values
//   - issue_bundle_t : registered operand/op bundle handed to execute
//   - f3_op()   : funct3 (+ alternate bit) to ALU op mapping
package riscv_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SLT = 4'd3;
  localparam logic [3:0] OP_ULT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [3:0]  op_sel;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_bundle_t;

  // alt selects SUB for funct3 000 and ASR for funct3 101; ignored otherwise
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = alt ? OP_SUB : OP_ADD;
      F3_SLL:  op = OP_SLL;
      F3_SLT:  op = OP_SLT;
      F3_SLTU: op = OP_ULT;
      F3_XOR:  op = OP_XOR;
      F3_SR:   op = alt ? OP_ASR : OP_LSR;
      F3_OR:   op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 architectural register file.
//   clk, reset_n     : clock, async active-low reset (all registers cleared)
//   i_ra1/o_rd1      : async read port 1
//   i_ra2/o_rd2      : async read port 2
//   i_we/i_wa/i_wd   : synchronous write port; writes to x0 are dropped
// A read of a register being written this cycle returns the old value.
module riscv_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  i_ra1,
  output logic [31:0] o_rd1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/riscv_decode_issue.sv
// riscv_decode_issue: RV32I decode + issue stage in front of the execute ALU.
//   clk, reset_n             : clock, async active-low reset
//   if_valid_i/if_ready_o    : fetch handshake; if_instr_i, if_pc_i payload
//   ex_valid_o/ex_ready_i    : issue handshake; ex_opr_a_o, ex_opr_b_o,
//                              ex_op_sel_o, ex_rd_o, ex_rd_we_o, ex_illegal_o
//   wb_en_i, wb_rd_i, wb_data_i : writeback into the register file
// Optional feature: define RISCV_WB_BYPASS_EN to forward writeback data to a
// dependent source in the writeback cycle (zero-bubble RAW resolution).
module riscv_decode_issue
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_opr_a_o,
  output logic [31:0] ex_opr_b_o,
  output logic [3:0]  ex_op_sel_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_rd_we_o,
  output logic        ex_illegal_o,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i
);

  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_legal, w_use1, w_use2, w_a_pc;
  logic [3:0]  w_op;
  logic [31:0] w_imm;
  logic [31:0] w_rf1, w_rf2, w_src1, w_src2;
  logic        w_byp1, w_byp2, w_haz, w_issue;
  issue_bundle_t w_bnd;
  logic [31:0] w_busy_nxt;

  issue_bundle_t r_out;
  logic          r_valid;
  logic [31:0]   r_busy;

  assign w_opc = if_instr_i[6:0];
  assign w_rd  = if_instr_i[11:7];
  assign w_f3  = if_instr_i[14:12];
  assign w_rs1 = if_instr_i[19:15];
  assign w_rs2 = if_instr_i[24:20];
  assign w_f7  = if_instr_i[31:25];

  always_comb begin
    w_legal = 1'b0;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_a_pc  = 1'b0;
    w_op    = OP_ADD;
    w_imm   = '0;
    case (w_opc)
      OPC_OP: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        w_op    = f3_op(w_f3, w_f7[5]);
      end
      OPC_OP_IMM: begin
        w_use1  = 1'b1;
        w_legal = 1'b1;
        w_imm   = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
        w_op    = f3_op(w_f3, 1'b0);
        if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
          // For shifts [31:25] is a function code; only the shamt is the operand.
          w_imm   = {27'd0, w_rs2};
          w_legal = (w_f7 == F7_BASE) || ((w_f3 == F3_SR) && (w_f7 == F7_ALT));
          w_op    = f3_op(w_f3, w_f7[5]);
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_imm   = {if_instr_i[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_a_pc  = 1'b1;
        w_imm   = {if_instr_i[31:12], 12'h000};
      end
      default: ;
    endcase
  end

  riscv_regfile u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_ra1   (w_rs1),
    .o_rd1   (w_rf1),
    .i_ra2   (w_rs2),
    .o_rd2   (w_rf2),
    .i_we    (wb_en_i),
    .i_wa    (wb_rd_i),
    .i_wd    (wb_data_i)
  );

`ifdef RISCV_WB_BYPASS_EN
  assign w_byp1 = wb_en_i && (wb_rd_i == w_rs1) && (w_rs1 != 5'd0);
  assign w_byp2 = wb_en_i && (wb_rd_i == w_rs2) && (w_rs2 != 5'd0);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_src1 = w_byp1 ? wb_data_i : w_rf1;
  assign w_src2 = w_byp2 ? wb_data_i : w_rf2;

  // Illegal instructions read nothing, so they never wait on the scoreboard.
  assign w_haz = w_legal &&
                 ((w_use1 && (w_rs1 != 5'd0) && r_busy[w_rs1] && !w_byp1) ||
                  (w_use2 && (w_rs2 != 5'd0) && r_busy[w_rs2] && !w_byp2));

  assign w_issue    = if_valid_i && !w_haz && (!r_valid || ex_ready_i);
  assign if_ready_o = w_issue;

  always_comb begin
    w_bnd = '0;
    if (!w_legal) begin
      w_bnd.illegal = 1'b1;
    end else begin
      w_bnd.opr_a  = w_a_pc ? if_pc_i : (w_use1 ? w_src1 : '0);
      w_bnd.opr_b  = w_use2 ? w_src2 : w_imm;
      w_bnd.op_sel = w_op;
      w_bnd.rd     = w_rd;
      w_bnd.rd_we  = (w_rd != 5'd0);
    end
  end

  // Set after clear so an issue to rd wins over a same-cycle writeback of rd.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en_i) w_busy_nxt[wb_rd_i] = 1'b0;
    if (w_issue && w_bnd.rd_we) w_busy_nxt[w_bnd.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_issue) begin
        r_valid <= 1'b1;
        r_out   <= w_bnd;
      end else if (ex_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_opr_a_o   = r_out.opr_a;
  assign ex_opr_b_o   = r_out.opr_b;
  assign ex_op_sel_o  = r_out.op_sel;
  assign ex_rd_o      = r_out.rd;
  assign ex_rd_we_o   = r_out.rd_we;
  assign ex_illegal_o = r_out.illegal;

endmodule
